checkpoint_seq_monitor: RTL and testbench
=========================================

// Module: checkpoint_seq_monitor
// PURPOSE
//  Hardware checkpoint monitor for the 16-bit checkbits bus (mprj_io[31:16]) in the user project.
//  Sequence per run:
//   - waits for a programmed start marker;
//   - matches up to DEPTH expected checkpoint values in order;
//   - waits for a programmed end marker;
//   - reports pass/fail/timeout and the cycle count from start to end.
//  Replaces bench-side wait()/$time checks so FIR/MM/qsort runs are checked and timed on-chip.
// PARAMETERS
//  WIDTH   16         checkbits width
//  DEPTH   8          max expected checkpoints per run (power of 2, >=2)
//  CNT_W   32         cycle counter width
//  TIMEOUT 2000000    cycles allowed in ARMED+RUN before timeout; 0 disables
//  STRICT  1          1: any unexpected update fails the run; 0: unexpected updates are ignored
// PORTS
//  wb_clk_i      in   1                 clock
//  wb_rst_i      in   1                 async reset, active-high
//  cfg_we        in   1                 write cfg_data to expected[cfg_addr]
//  cfg_addr      in   $clog2(DEPTH)     expected-table index
//  cfg_data      in   WIDTH             expected value
//  cfg_len       in   $clog2(DEPTH)+1   checkpoints to match, 0..DEPTH; sampled at arm
//  cfg_start     in   WIDTH             start marker; sampled at arm
//  cfg_end       in   WIDTH             end marker; sampled at arm
//  arm_i         in   1                 start a run (pulse)
//  abort_i       in   1                 return to IDLE, no result
//  checkbits_i   in   WIDTH             observed bus, synchronous to wb_clk_i
//  busy_o        out  1                 high in ARMED or RUN
//  hit_o         out  1                 1-cycle pulse per matched checkpoint
//  hit_idx_o     out  $clog2(DEPTH)     index of the last matched checkpoint
//  done_o        out  1                 1-cycle pulse on run completion
//  pass_o        out  1                 result flag, held until next arm
//  fail_o        out  1                 result flag, held until next arm
//  timeout_o     out  1                 result flag, held until next arm
//  cycles_o      out  CNT_W             measured cycles, held until next arm
// BEHAVIOUR
//  - Reset values:
//    - all outputs 0; state IDLE; idx 0; counter 0;
//    - prev register 0; expected table 0.
//  - Update events:
//    - prev register captures checkbits_i every cycle in all states.
//    - upd = (checkbits_i != prev); only update cycles are evaluated.
//    - A value already present at arm time is not an update.
//  - All outputs are registered; results appear on the edge after the deciding cycle.
//  - FSM IDLE:
//    - arm_i latches cfg_len, cfg_start and cfg_end.
//    - Clears pass/fail/timeout/cycles/idx; goes to ARMED.
//  - FSM ARMED:
//    - upd with value == start marker: counter := 0, go to RUN.
//    - Other updates are ignored in both STRICT modes.
//  - FSM RUN: counter +1 per cycle, saturating at all-ones. On upd, evaluated in this order:
//    - (1) idx < len and value == expected[idx]: hit_o=1, hit_idx_o=idx, idx+1.
//    - (2) idx == len and value == end marker: cycles_o := counter+1, pass_o=1, done_o=1, go to DONE.
//    - (3) value == end marker with idx < len: fail_o=1, done_o=1, go to DONE.
//    - (4) any other update: if STRICT, fail_o=1, done_o=1, go to DONE; otherwise ignore.
//  - Overlapping values:
//    - Expected value equal to the end marker: rule (1) wins while idx < len.
//    - len=0: the first update equal to the end marker passes.
//  - Timeout (TIMEOUT != 0): a separate wait counter runs in ARMED and RUN.
//    - On reaching TIMEOUT: timeout_o=1, fail_o=1, done_o=1, go to DONE.
//    - cycles_o := counter; an update in the same cycle is not evaluated.
//  - FSM DONE:
//    - Result flags held; busy_o=0.
//    - arm_i starts a new run exactly as from IDLE.
//  - Ignored inputs:
//    - arm_i while busy.
//    - cfg_we while busy, so the table is stable during a run.
//    - cfg_len > DEPTH is clamped to DEPTH.
//  - abort_i: from any state go to IDLE.
//    - Clears busy; flags are left unchanged; no done_o.
//    - abort_i wins over a simultaneous arm_i, update or timeout.
//  - wb_rst_i mid-run: immediate return to reset values; no done_o.
// TESTING
//  - Happy path:
//    - Program FFF6,FFE7,009E,02DC, len=4, start AB40, end AB55.
//    - Drive AB40, the four values, then AB55 1000 cycles after AB40.
//    - Expect 4 hit_o pulses with hit_idx_o 0..3, then pass_o=1, cycles_o=1000, one done_o.
//  - Early end:
//    - len=4, drive AB41,003E,AB52.
//    - Expect fail_o=1, pass_o=0, hit count 1.
//  - STRICT compare, same stimulus run once with STRICT=1 and once with STRICT=0:
//    - Stimulus: AB42,0028,1234,037D,09ED,0A6D,AB53.
//    - STRICT=1: fail at 1234.
//    - STRICT=0: pass, 4 hits.
//  - Timeout:
//    - TIMEOUT=500, arm, never drive the start marker.
//    - Expect done_o at cycle 500 after arm, timeout_o=1, fail_o=1.
//  - Abort / reset:
//    - abort_i after 2 hits: busy_o=0, no done_o; re-arm then passes a full sequence.
//    - wb_rst_i mid-run: all outputs 0.
//  - Corners:
//    - Checkbits already equal AB40 at arm: stays ARMED.
//    - arm_i while busy and cfg_we while busy: no effect.
//    - len=0: start then end passes.

Source files
------------

// File: rtl/checkpoint_seq_monitor.sv
// Checkpoint sequence monitor for the checkbits bus.
// Waits for a start marker, matches an ordered list of expected values,
// then waits for an end marker, reporting pass/fail/timeout and run length.
module checkpoint_seq_monitor #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 2000000,
  parameter int STRICT  = 1
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [WIDTH-1:0]         cfg_data,
  input  logic [$clog2(DEPTH):0]   cfg_len,
  input  logic [WIDTH-1:0]         cfg_start,
  input  logic [WIDTH-1:0]         cfg_end,
  input  logic                     arm_i,
  input  logic                     abort_i,
  input  logic [WIDTH-1:0]         checkbits_i,
  output logic                     busy_o,
  output logic                     hit_o,
  output logic [$clog2(DEPTH)-1:0] hit_idx_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     fail_o,
  output logic                     timeout_o,
  output logic [CNT_W-1:0]         cycles_o
);

  localparam int              AW      = $clog2(DEPTH);
  localparam int              TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT - 1) : '0;
  localparam logic [AW:0]     LEN_MAX = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] exp_tab [DEPTH];
  logic [WIDTH-1:0] prev_p1;
  logic [WIDTH-1:0] start_r;
  logic [WIDTH-1:0] end_r;
  logic [AW:0]      len_r;
  logic [AW:0]      idx;
  logic [CNT_W-1:0] cnt;
  logic [TO_W-1:0]  wait_cnt;

  logic             upd;
  logic             exp_hit;
  logic             is_end;
  logic             to_fire;
  logic [WIDTH-1:0] exp_val;

  // Lengths above the table size are treated as a full table.
  function automatic logic [AW:0] clamp_len(input logic [AW:0] len);
    return (len > LEN_MAX) ? LEN_MAX : len;
  endfunction

  // Cycle counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Decode of the current bus sample against the armed run configuration.
  always_comb begin
    upd     = (checkbits_i != prev_p1);
    exp_val = exp_tab[idx[AW-1:0]];
    exp_hit = (idx < len_r) && (checkbits_i == exp_val);
    is_end  = (checkbits_i == end_r);
    to_fire = TO_EN && (wait_cnt == TO_LAST);
  end

  // Previous bus value, captured every cycle so only changes count as updates.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) prev_p1 <= '0;
    else          prev_p1 <= checkbits_i;
  end

  // Expected-value table; writes are locked out during a run.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < DEPTH; i++) exp_tab[i] <= '0;
    end else if (cfg_we && !busy_o) begin
      exp_tab[cfg_addr] <= cfg_data;
    end
  end

  // Run sequencer with registered status and result outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      busy_o    <= 1'b0;
      hit_o     <= 1'b0;
      hit_idx_o <= '0;
      done_o    <= 1'b0;
      pass_o    <= 1'b0;
      fail_o    <= 1'b0;
      timeout_o <= 1'b0;
      cycles_o  <= '0;
      len_r     <= '0;
      start_r   <= '0;
      end_r     <= '0;
      idx       <= '0;
      cnt       <= '0;
      wait_cnt  <= '0;
    end else begin
      hit_o  <= 1'b0;
      done_o <= 1'b0;
      if (abort_i) begin
        state  <= S_IDLE;
        busy_o <= 1'b0;
      end else if (busy_o && to_fire) begin
        // Timeout takes precedence over any update seen this cycle.
        cycles_o  <= cnt;
        timeout_o <= 1'b1;
        fail_o    <= 1'b1;
        done_o    <= 1'b1;
        busy_o    <= 1'b0;
        state     <= S_DONE;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (arm_i) begin
              len_r     <= clamp_len(cfg_len);
              start_r   <= cfg_start;
              end_r     <= cfg_end;
              pass_o    <= 1'b0;
              fail_o    <= 1'b0;
              timeout_o <= 1'b0;
              cycles_o  <= '0;
              idx       <= '0;
              cnt       <= '0;
              wait_cnt  <= '0;
              busy_o    <= 1'b1;
              state     <= S_ARMED;
            end
          end
          S_ARMED: begin
            wait_cnt <= wait_cnt + 1'b1;
            if (upd && (checkbits_i == start_r)) begin
              cnt   <= '0;
              state <= S_RUN;
            end
          end
          S_RUN: begin
            wait_cnt <= wait_cnt + 1'b1;
            cnt      <= sat_inc(cnt);
            if (upd) begin
              if (exp_hit) begin
                hit_o     <= 1'b1;
                hit_idx_o <= idx[AW-1:0];
                idx       <= idx + 1'b1;
              end else if ((idx == len_r) && is_end) begin
                cycles_o <= sat_inc(cnt);
                pass_o   <= 1'b1;
                done_o   <= 1'b1;
                busy_o   <= 1'b0;
                state    <= S_DONE;
              end else if (is_end || (STRICT != 0)) begin
                // End marker seen early, or an unexpected value in strict mode.
                fail_o <= 1'b1;
                done_o <= 1'b1;
                busy_o <= 1'b0;
                state  <= S_DONE;
              end
            end
          end
          default: begin
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Directed bench for checkpoint_seq_monitor: one strict instance, one
// non-strict instance and one short-timeout instance share the same stimulus.
module tb_checkpoint_seq_monitor;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int CNT_W = 32;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cfg_we = 1'b0;
  logic [AW-1:0]    cfg_addr = '0;
  logic [WIDTH-1:0] cfg_data = '0;
  logic [AW:0]      cfg_len = '0;
  logic [WIDTH-1:0] cfg_start = '0;
  logic [WIDTH-1:0] cfg_end = '0;
  logic             arm = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] checkbits = '0;

  logic busy_s, hit_s, done_s, pass_s, fail_s, to_s;
  logic busy_n, hit_n, done_n, pass_n, fail_n, to_n;
  logic busy_t, hit_t, done_t, pass_t, fail_t, to_t;
  logic [AW-1:0]    hidx_s, hidx_n, hidx_t;
  logic [CNT_W-1:0] cyc_s, cyc_n, cyc_t;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  checkpoint_seq_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(2000000), .STRICT(1)) dut_s (
    .wb_clk_i(clk), .wb_rst_i(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_len(cfg_len), .cfg_start(cfg_start), .cfg_end(cfg_end), .arm_i(arm), .abort_i(abort),
    .checkbits_i(checkbits), .busy_o(busy_s), .hit_o(hit_s), .hit_idx_o(hidx_s), .done_o(done_s),
    .pass_o(pass_s), .fail_o(fail_s), .timeout_o(to_s), .cycles_o(cyc_s));

  checkpoint_seq_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(2000000), .STRICT(0)) dut_n (
    .wb_clk_i(clk), .wb_rst_i(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_len(cfg_len), .cfg_start(cfg_start), .cfg_end(cfg_end), .arm_i(arm), .abort_i(abort),
    .checkbits_i(checkbits), .busy_o(busy_n), .hit_o(hit_n), .hit_idx_o(hidx_n), .done_o(done_n),
    .pass_o(pass_n), .fail_o(fail_n), .timeout_o(to_n), .cycles_o(cyc_n));

  checkpoint_seq_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(500), .STRICT(1)) dut_t (
    .wb_clk_i(clk), .wb_rst_i(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_len(cfg_len), .cfg_start(cfg_start), .cfg_end(cfg_end), .arm_i(arm), .abort_i(abort),
    .checkbits_i(checkbits), .busy_o(busy_t), .hit_o(hit_t), .hit_idx_o(hidx_t), .done_o(done_t),
    .pass_o(pass_t), .fail_o(fail_t), .timeout_o(to_t), .cycles_o(cyc_t));

  // Pulse counters, sampled on the falling edge.
  int            hits_s = 0, hits_n = 0, dones_s = 0, dones_n = 0;
  logic [AW-1:0] idx_log [8];
  logic          clr = 1'b0;

  always @(negedge clk) begin
    if (clr) begin
      hits_s <= 0; hits_n <= 0; dones_s <= 0; dones_n <= 0;
    end else begin
      if (hit_s) begin
        if (hits_s < 8) idx_log[hits_s] <= hidx_s;
        hits_s <= hits_s + 1;
      end
      if (hit_n)  hits_n  <= hits_n + 1;
      if (done_s) dones_s <= dones_s + 1;
      if (done_n) dones_n <= dones_n + 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [WIDTH-1:0] v);
    checkbits = v;
    cyc(1);
  endtask

  task automatic prog(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    cyc(1);
    cfg_we = 1'b0;
  endtask

  task automatic arm_run(input logic [AW:0] len, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] e);
    cfg_len = len; cfg_start = s; cfg_end = e; arm = 1'b1;
    cyc(1);
    arm = 1'b0;
  endtask

  task automatic clear_counts();
    clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
    cyc(1);
  endtask

  task automatic prog_std();
    prog(0, 16'hFFF6); prog(1, 16'hFFE7); prog(2, 16'h009E); prog(3, 16'h02DC);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(2);
    n_tests++;
    if ({busy_s, hit_s, done_s, pass_s, fail_s, to_s} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000000", {busy_s, hit_s, done_s, pass_s, fail_s, to_s});
    end
    n_tests++;
    if ({hidx_s, cyc_s} !== '0) begin
      n_fail++; $display("FAIL reset_vals: got idx=%0d cycles=%0d want 0 0", hidx_s, cyc_s);
    end
    n_tests++;
    if ({busy_n, hit_n, done_n, pass_n, fail_n, to_n, hidx_n, cyc_n,
         busy_t, hit_t, done_t, pass_t, fail_t, to_t, hidx_t, cyc_t} !== '0) begin
      n_fail++; $display("FAIL reset_other: got nonzero outputs on second/third instance, want all 0");
    end
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_happy();
    prog_std();
    clear_counts();
    arm_run(4, 16'hAB40, 16'hAB55);
    n_tests++;
    if (busy_s !== 1'b1) begin n_fail++; $display("FAIL happy_busy: got %b want 1", busy_s); end
    drive(16'hAB40); drive(16'hFFF6); drive(16'hFFE7); drive(16'h009E); drive(16'h02DC);
    cyc(995);
    drive(16'hAB55);
    n_tests++;
    if ({done_s, pass_s, fail_s, busy_s} !== 4'b1100) begin
      n_fail++; $display("FAIL happy_result: got done/pass/fail/busy=%b want 1100", {done_s, pass_s, fail_s, busy_s});
    end
    n_tests++;
    if (cyc_s !== 32'd1000) begin n_fail++; $display("FAIL happy_cycles: got %0d want 1000", cyc_s); end
    cyc(2);
    n_tests++;
    if (hits_s !== 4 || dones_s !== 1) begin
      n_fail++; $display("FAIL happy_counts: got hits=%0d dones=%0d want 4 1", hits_s, dones_s);
    end
    n_tests++;
    if ({idx_log[0], idx_log[1], idx_log[2], idx_log[3]} !== {3'd0, 3'd1, 3'd2, 3'd3}) begin
      n_fail++; $display("FAIL happy_hit_idx: got %0d %0d %0d %0d want 0 1 2 3",
                         idx_log[0], idx_log[1], idx_log[2], idx_log[3]);
    end
  endtask

  task automatic test_early_end();
    prog(0, 16'h003E); prog(1, 16'h0111); prog(2, 16'h0222); prog(3, 16'h0333);
    clear_counts();
    arm_run(4, 16'hAB41, 16'hAB52);
    drive(16'hAB41); drive(16'h003E); drive(16'hAB52);
    n_tests++;
    if ({done_s, pass_s, fail_s} !== 3'b101) begin
      n_fail++; $display("FAIL early_end_result: got done/pass/fail=%b want 101", {done_s, pass_s, fail_s});
    end
    cyc(2);
    n_tests++;
    if (hits_s !== 1) begin n_fail++; $display("FAIL early_end_hits: got %0d want 1", hits_s); end
  endtask

  task automatic test_strict();
    prog(0, 16'h0028); prog(1, 16'h037D); prog(2, 16'h09ED); prog(3, 16'h0A6D);
    clear_counts();
    arm_run(4, 16'hAB42, 16'hAB53);
    drive(16'hAB42); drive(16'h0028); drive(16'h1234);
    n_tests++;
    if ({done_s, pass_s, fail_s} !== 3'b101) begin
      n_fail++; $display("FAIL strict1_at_1234: got done/pass/fail=%b want 101", {done_s, pass_s, fail_s});
    end
    drive(16'h037D); drive(16'h09ED); drive(16'h0A6D); drive(16'hAB53);
    n_tests++;
    if ({done_n, pass_n, fail_n} !== 3'b110) begin
      n_fail++; $display("FAIL strict0_result: got done/pass/fail=%b want 110", {done_n, pass_n, fail_n});
    end
    n_tests++;
    if (cyc_n !== 32'd6) begin n_fail++; $display("FAIL strict0_cycles: got %0d want 6", cyc_n); end
    cyc(2);
    n_tests++;
    if (hits_s !== 1 || hits_n !== 4 || dones_s !== 1 || dones_n !== 1) begin
      n_fail++; $display("FAIL strict_counts: got hits_s=%0d hits_n=%0d dones_s=%0d dones_n=%0d want 1 4 1 1",
                         hits_s, hits_n, dones_s, dones_n);
    end
  endtask

  task automatic test_timeout();
    int k;
    clear_counts();
    arm_run(4, 16'hAB44, 16'hAB45);
    k = 0;
    for (int i = 1; i <= 600; i++) begin
      cyc(1);
      if (done_t) begin k = i; break; end
    end
    n_tests++;
    if (k !== 500) begin n_fail++; $display("FAIL timeout_latency: got %0d want 500 (0 = never)", k); end
    n_tests++;
    if ({to_t, fail_t, pass_t, busy_t} !== 4'b1100 || cyc_t !== 32'd0) begin
      n_fail++; $display("FAIL timeout_flags: got to/fail/pass/busy=%b cycles=%0d want 1100 0",
                         {to_t, fail_t, pass_t, busy_t}, cyc_t);
    end
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    n_tests++;
    if (busy_s !== 1'b0 || busy_n !== 1'b0) begin
      n_fail++; $display("FAIL timeout_abort_busy: got %b%b want 00", busy_s, busy_n);
    end
  endtask

  task automatic test_abort();
    prog_std();
    clear_counts();
    arm_run(4, 16'hAB40, 16'hAB55);
    drive(16'hAB40); drive(16'hFFF6); drive(16'hFFE7);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    n_tests++;
    if ({busy_s, done_s, pass_s, fail_s} !== 4'b0000) begin
      n_fail++; $display("FAIL abort_state: got busy/done/pass/fail=%b want 0000", {busy_s, done_s, pass_s, fail_s});
    end
    cyc(2);
    n_tests++;
    if (hits_s !== 2 || dones_s !== 0) begin
      n_fail++; $display("FAIL abort_counts: got hits=%0d dones=%0d want 2 0", hits_s, dones_s);
    end
    arm_run(4, 16'hAB40, 16'hAB55);
    drive(16'hAB40); drive(16'hFFF6); drive(16'hFFE7); drive(16'h009E); drive(16'h02DC); drive(16'hAB55);
    n_tests++;
    if ({done_s, pass_s, fail_s} !== 3'b110 || cyc_s !== 32'd5) begin
      n_fail++; $display("FAIL abort_rearm: got done/pass/fail=%b cycles=%0d want 110 5", {done_s, pass_s, fail_s}, cyc_s);
    end
  endtask

  task automatic test_reset_mid_run();
    clear_counts();
    arm_run(4, 16'hAB40, 16'hAB55);
    drive(16'hAB40); drive(16'hFFF6);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({busy_s, hit_s, done_s, pass_s, fail_s, to_s, hidx_s, cyc_s} !== '0) begin
      n_fail++; $display("FAIL reset_mid_run: got busy=%b hit=%b idx=%0d cycles=%0d want all 0",
                         busy_s, hit_s, hidx_s, cyc_s);
    end
    cyc(1);
    rst = 1'b0;
    cyc(2);
    n_tests++;
    if (dones_s !== 0) begin n_fail++; $display("FAIL reset_no_done: got %0d want 0", dones_s); end
  endtask

  task automatic test_corners();
    // Start marker already on the bus when armed.
    prog_std();
    checkbits = 16'hAB40;
    cyc(1);
    clear_counts();
    arm_run(4, 16'hAB40, 16'hAB55);
    cyc(3);
    drive(16'hFFF6);
    cyc(1);
    n_tests++;
    if (busy_s !== 1'b1 || hits_s !== 0) begin
      n_fail++; $display("FAIL corner_preexisting: got busy=%b hits=%0d want 1 0", busy_s, hits_s);
    end
    // Arm and table write while busy must be ignored.
    cfg_we = 1'b1; cfg_addr = 0; cfg_data = 16'h1111;
    cfg_len = 0; cfg_start = 16'hAB66; arm = 1'b1;
    cyc(1);
    cfg_we = 1'b0; arm = 1'b0;
    drive(16'hAB40); drive(16'hFFF6); drive(16'hFFE7); drive(16'h009E); drive(16'h02DC); drive(16'hAB55);
    n_tests++;
    if ({done_s, pass_s, fail_s} !== 3'b110) begin
      n_fail++; $display("FAIL corner_busy_ignore: got done/pass/fail=%b want 110", {done_s, pass_s, fail_s});
    end
    cyc(2);
    n_tests++;
    if (hits_s !== 4) begin n_fail++; $display("FAIL corner_busy_hits: got %0d want 4", hits_s); end
    // Zero-length run: start then end passes.
    clear_counts();
    arm_run(0, 16'hAB40, 16'hAB55);
    drive(16'hAB40); drive(16'hAB55);
    n_tests++;
    if ({done_s, pass_s, fail_s} !== 3'b110 || cyc_s !== 32'd1) begin
      n_fail++; $display("FAIL corner_len0: got done/pass/fail=%b cycles=%0d want 110 1", {done_s, pass_s, fail_s}, cyc_s);
    end
    // Oversized length is clamped to the table depth.
    for (int i = 0; i < DEPTH; i++) prog(AW'(i), 16'h0100 + 16'(i));
    clear_counts();
    arm_run(4'd15, 16'hAB40, 16'hAB55);
    drive(16'hAB40);
    for (int i = 0; i < DEPTH; i++) drive(16'h0100 + 16'(i));
    drive(16'hAB55);
    n_tests++;
    if ({done_s, pass_s, fail_s} !== 3'b110 || cyc_s !== 32'd9) begin
      n_fail++; $display("FAIL corner_len_clamp: got done/pass/fail=%b cycles=%0d want 110 9", {done_s, pass_s, fail_s}, cyc_s);
    end
    cyc(2);
    n_tests++;
    if (hits_s !== 8) begin n_fail++; $display("FAIL corner_clamp_hits: got %0d want 8", hits_s); end
  endtask

  initial begin
    #1;
    test_reset();
    test_happy();
    test_early_end();
    test_strict();
    test_timeout();
    test_abort();
    test_reset_mid_run();
    test_corners();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
